// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: per-register countdown scoreboard granting two in-order issue slots, with saturating perf counters
module dual_issue_scoreboard #(
  parameter int NREG     = 32,
  parameter int LOAD_LAT = 2,
  parameter int MAC_LAT  = 3,
  parameter int MAC_PIPE = 1,
  parameter int NUM_MAC  = 2,
  parameter int FWD_EN   = 1,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_valid,
  input  logic              s1_valid,
  input  logic [4:0]        s0_rs1,
  input  logic [4:0]        s0_rs2,
  input  logic [4:0]        s0_rd,
  input  logic [4:0]        s1_rs1,
  input  logic [4:0]        s1_rs2,
  input  logic [4:0]        s1_rd,
  input  logic              s0_we,
  input  logic              s1_we,
  input  logic              s0_mem,
  input  logic              s1_mem,
  input  logic              s0_load,
  input  logic              s1_load,
  input  logic              s0_mac,
  input  logic              s1_mac,
  input  logic              s0_ctrl,
  input  logic              flush,
  output logic              issue0,
  output logic              issue1,
  output logic              stall,
  output logic [NREG-1:0]   busy_vec,
  output logic [PERF_W-1:0] perf_dual,
  output logic [PERF_W-1:0] perf_single,
  output logic [PERF_W-1:0] perf_stall
);
  logic [2:0] cnt [NREG];
  logic [2:0] mac_cnt;
  logic [2:0] lat0, lat1;
  logic       pair;
  logic       counted;

  function automatic logic src_ok(input logic [4:0] r);
    return r == 5'd0 || cnt[r] == 3'd0 || (FWD_EN != 0 && cnt[r] == 3'd1);
  endfunction

  function automatic logic slot_ok(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic we, input logic mac, input logic [2:0] lat);
    return src_ok(rs1) && src_ok(rs2) && (!we || rd == 5'd0 || cnt[rd] < lat) &&
           (!mac || MAC_PIPE != 0 || mac_cnt == 3'd0);
  endfunction

  assign lat0 = s0_mac ? 3'(MAC_LAT) : s0_load ? 3'(LOAD_LAT) : 3'd1;
  assign lat1 = s1_mac ? 3'(MAC_LAT) : s1_load ? 3'(LOAD_LAT) : 3'd1;

  // no intra-bundle bypass, so any slot-0 result slot 1 touches splits the bundle
  assign pair = (s0_we && s0_rd != 5'd0 && (s0_rd == s1_rs1 || s0_rd == s1_rs2)) ||
                (s0_we && s1_we && s0_rd != 5'd0 && s0_rd == s1_rd) ||
                (s0_mem && s1_mem) ||
                ((NUM_MAC == 1 || MAC_PIPE == 0) && s0_mac && s1_mac);

  assign issue0  = reset && s0_valid && !flush && slot_ok(s0_rs1, s0_rs2, s0_rd, s0_we, s0_mac, lat0);
  assign issue1  = issue0 && s1_valid && !s0_ctrl && !pair && slot_ok(s1_rs1, s1_rs2, s1_rd, s1_we, s1_mac, lat1);
  assign stall   = reset && s0_valid && !issue0;
  assign counted = s0_valid && !flush;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic set0, set1;
    assign set0 = i != 0 && issue0 && s0_we && s0_rd == 5'(i);
    assign set1 = i != 0 && issue1 && s1_we && s1_rd == 5'(i);
    always_ff @(posedge clk or negedge reset)
      if (!reset) cnt[i] <= '0;
      else if (set0) cnt[i] <= lat0;
      else if (set1) cnt[i] <= lat1;
      else if (cnt[i] != 3'd0) cnt[i] <= cnt[i] - 3'd1;
    assign busy_vec[i] = cnt[i] != 3'd0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) mac_cnt <= '0;
    else if (MAC_PIPE == 0 && ((issue0 && s0_mac) || (issue1 && s1_mac))) mac_cnt <= 3'(MAC_LAT - 1);
    else if (mac_cnt != 3'd0) mac_cnt <= mac_cnt - 3'd1;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_dual   <= '0;
      perf_single <= '0;
      perf_stall  <= '0;
    end else if (counted) begin
      if (issue1 && perf_dual != '1) perf_dual <= perf_dual + 1'b1;
      if (issue0 && !issue1 && perf_single != '1) perf_single <= perf_single + 1'b1;
      if (!issue0 && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb_dual_issue_scoreboard: two configurations (A: defaults, B: 1 MAC, unpipelined, no bypass) driven in lockstep against a reference model
module tb_dual_issue_scoreboard;
  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       we, mem, load, mac;
  } slot_t;
  typedef struct packed {
    logic        i0, i1, st;
    logic [31:0] bv;
    logic [3:0]  pd, ps, pt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  slot_t       c0, c1;
  logic        ctl, fl;
  logic        g0 [2];
  logic        g1 [2];
  logic        st [2];
  logic [31:0] bv [2];
  logic [3:0]  pd [2];
  logic [3:0]  ps [2];
  logic [3:0]  pt [2];
  int          mc [2][32];
  int          mm [2];
  int          pf [2][3];
  exp_t        q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  slot_t       nop = '0;

  always #5 clk = ~clk;

  dual_issue_scoreboard #(.PERF_W(4)) u_a (
    .clk(clk), .reset(reset), .s0_valid(c0.v), .s1_valid(c1.v),
    .s0_rs1(c0.rs1), .s0_rs2(c0.rs2), .s0_rd(c0.rd), .s1_rs1(c1.rs1), .s1_rs2(c1.rs2), .s1_rd(c1.rd),
    .s0_we(c0.we), .s1_we(c1.we), .s0_mem(c0.mem), .s1_mem(c1.mem), .s0_load(c0.load), .s1_load(c1.load),
    .s0_mac(c0.mac), .s1_mac(c1.mac), .s0_ctrl(ctl), .flush(fl),
    .issue0(g0[0]), .issue1(g1[0]), .stall(st[0]), .busy_vec(bv[0]),
    .perf_dual(pd[0]), .perf_single(ps[0]), .perf_stall(pt[0]));

  dual_issue_scoreboard #(.NUM_MAC(1), .MAC_PIPE(0), .FWD_EN(0), .PERF_W(4)) u_b (
    .clk(clk), .reset(reset), .s0_valid(c0.v), .s1_valid(c1.v),
    .s0_rs1(c0.rs1), .s0_rs2(c0.rs2), .s0_rd(c0.rd), .s1_rs1(c1.rs1), .s1_rs2(c1.rs2), .s1_rd(c1.rd),
    .s0_we(c0.we), .s1_we(c1.we), .s0_mem(c0.mem), .s1_mem(c1.mem), .s0_load(c0.load), .s1_load(c1.load),
    .s0_mac(c0.mac), .s1_mac(c1.mac), .s0_ctrl(ctl), .flush(fl),
    .issue0(g0[1]), .issue1(g1[1]), .stall(st[1]), .busy_vec(bv[1]),
    .perf_dual(pd[1]), .perf_single(ps[1]), .perf_stall(pt[1]));

  function automatic slot_t op(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                               logic we = 1'b1, logic mem = 1'b0, logic load = 1'b0, logic mac = 1'b0);
    return '{v: 1'b1, rs1: rs1, rs2: rs2, rd: rd, we: we, mem: mem, load: load, mac: mac};
  endfunction

  function automatic slot_t rnd();
    slot_t s;
    s.v    = ($urandom % 4) != 0;
    s.rs1  = 5'($urandom_range(7));
    s.rs2  = 5'($urandom_range(7));
    s.rd   = 5'($urandom_range(7));
    s.we   = ($urandom % 4) != 0;
    s.mac  = ($urandom % 5) == 0;
    s.load = !s.mac && ($urandom % 4) == 0;
    s.mem  = s.load || ($urandom % 6) == 0;
    return s;
  endfunction

  function automatic int lat(slot_t s);
    return s.mac ? 3 : s.load ? 2 : 1;
  endfunction

  // model k=0 forwards at count 1 and has a pipelined pair of MACs; k=1 does neither
  function automatic bit ok(int k, slot_t s);
    bit src1, src2, waw, mac;
    src1 = s.rs1 == 0 || mc[k][s.rs1] == 0 || (k == 0 && mc[k][s.rs1] == 1);
    src2 = s.rs2 == 0 || mc[k][s.rs2] == 0 || (k == 0 && mc[k][s.rs2] == 1);
    waw  = !s.we || s.rd == 0 || mc[k][s.rd] < lat(s);
    mac  = !s.mac || k == 0 || mm[k] == 0;
    return src1 && src2 && waw && mac;
  endfunction

  function automatic void grant(int k, output bit o0, output bit o1);
    bit hz;
    hz = (c0.we && c0.rd != 0 && (c0.rd == c1.rs1 || c0.rd == c1.rs2)) ||
         (c0.we && c1.we && c0.rd != 0 && c0.rd == c1.rd) || (c0.mem && c1.mem) ||
         (k == 1 && c0.mac && c1.mac);
    o0 = reset && c0.v && !fl && ok(k, c0);
    o1 = o0 && c1.v && !ctl && ok(k, c1) && !hz;
  endfunction

  function automatic void mclear(int k);
    for (int r = 0; r < 32; r++) mc[k][r] = 0;
    mm[k] = 0;
    for (int e = 0; e < 3; e++) pf[k][e] = 0;
  endfunction

  function automatic exp_t mexp(int k);
    exp_t e;
    bit o0, o1;
    grant(k, o0, o1);
    e.i0 = o0;
    e.i1 = o1;
    e.st = reset && c0.v && !o0;
    for (int r = 0; r < 32; r++) e.bv[r] = r != 0 && mc[k][r] != 0;
    e.pd = 4'(pf[k][0]);
    e.ps = 4'(pf[k][1]);
    e.pt = 4'(pf[k][2]);
    return e;
  endfunction

  function automatic void mstep(int k);
    bit o0, o1;
    int ev;
    grant(k, o0, o1);
    if (!reset) begin
      mclear(k);
      return;
    end
    if (c0.v && !fl) begin
      ev = o1 ? 0 : o0 ? 1 : 2;
      if (pf[k][ev] < 15) pf[k][ev]++;
    end
    for (int r = 1; r < 32; r++) if (mc[k][r] > 0) mc[k][r]--;
    if (o0 && c0.we && c0.rd != 0) mc[k][c0.rd] = lat(c0);
    if (o1 && c1.we && c1.rd != 0) mc[k][c1.rd] = lat(c1);
    if (k == 1) begin
      if ((o0 && c0.mac) || (o1 && c1.mac)) mm[k] = 2;
      else if (mm[k] > 0) mm[k]--;
    end
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic cyc(slot_t a, slot_t b, logic ct = 1'b0, logic f = 1'b0);
    exp_t e;
    @(negedge clk);
    c0 = a;
    c1 = b;
    ctl = ct;
    fl = f;
    for (int k = 0; k < 2; k++) q.push_back(mexp(k));
    #1;
    for (int k = 0; k < 2; k++) begin
      e = q.pop_front();
      check($sformatf("issue0_%0d", k), 32'(g0[k]), 32'(e.i0));
      check($sformatf("issue1_%0d", k), 32'(g1[k]), 32'(e.i1));
      check($sformatf("stall_%0d", k), 32'(st[k]), 32'(e.st));
      check($sformatf("busy_%0d", k), bv[k], e.bv);
      check($sformatf("pdual_%0d", k), 32'(pd[k]), 32'(e.pd));
      check($sformatf("psingle_%0d", k), 32'(ps[k]), 32'(e.ps));
      check($sformatf("pstall_%0d", k), 32'(pt[k]), 32'(e.pt));
    end
    for (int k = 0; k < 2; k++) mstep(k);
  endtask

  task automatic release_reset();
    c0 = '0;
    c1 = '0;
    reset = 1'b1;
  endtask

  initial begin
    c0 = '0;
    c1 = '0;
    ctl = 1'b0;
    fl = 1'b0;
    mclear(0);
    mclear(1);
    cyc(op(5, 1, 2), op(6, 3, 4));
    check("rst_issue0", 32'(g0[0]), 32'd0);
    release_reset();
    // dual issue of independent ADDs
    cyc(op(5, 1, 2), op(6, 3, 4));
    check("t1_issue1", 32'(g1[0]), 32'd1);
    cyc(nop, nop);
    check("t1_busy5", 32'(bv[0][5]), 32'd1);
    check("t1_busy6", 32'(bv[0][6]), 32'd1);
    check("t1_pdual", 32'(pd[0]), 32'd1);
    // load-use: one stall with bypass, two without
    cyc(op(7, 1, 0, 1, 1, 1), nop);
    cyc(op(8, 7, 1), nop);
    check("t2_stall_a", 32'(st[0]), 32'd1);
    check("t2_stall_b", 32'(st[1]), 32'd1);
    cyc(op(8, 7, 1), nop);
    check("t2_issue_a", 32'(g0[0]), 32'd1);
    check("t2_stall2_b", 32'(st[1]), 32'd1);
    cyc(op(8, 7, 1), nop);
    check("t2_issue_b", 32'(g0[1]), 32'd1);
    // intra-bundle RAW
    cyc(op(9, 1, 2), op(3, 9, 4));
    check("t3_issue0", 32'(g0[0]), 32'd1);
    check("t3_issue1", 32'(g1[0]), 32'd0);
    cyc(op(3, 9, 4), nop);
    check("t3_next", 32'(g0[0]), 32'd1);
    // memory port and MAC structural hazards
    cyc(op(12, 1, 0, 1, 1, 1), op(0, 2, 0, 0, 1, 0));
    check("t4_mem", 32'(g1[0]), 32'd0);
    cyc(op(13, 1, 2, 1, 0, 0, 1), op(14, 5, 6, 1, 0, 0, 1));
    check("t4_mac_a", 32'(g1[0]), 32'd1);
    check("t4_mac_b", 32'(g1[1]), 32'd0);
    for (int i = 0; i < 4; i++) cyc(nop, nop);
    for (int i = 0; i < 4; i++) begin
      cyc(op(5'(16 + i), 0, 0, 1, 0, 0, 1), nop);
      check($sformatf("t4_macseq_a%0d", i), 32'(g0[0]), 32'd1);
      check($sformatf("t4_macseq_b%0d", i), 32'(g0[1]), 32'(i == 0 || i == 3));
    end
    // cross-cycle WAW after a MAC, then a flushed bundle
    for (int i = 0; i < 4; i++) cyc(nop, nop);
    cyc(op(10, 0, 0, 1, 0, 0, 1), nop);
    for (int i = 0; i < 4; i++) begin
      cyc(op(10, 1, 2), nop);
      check($sformatf("t5_waw%0d", i), 32'(g0[0]), 32'(i == 3));
    end
    cyc(op(20, 1, 2), op(21, 3, 4), 1'b0, 1'b1);
    check("t5_flush0", 32'(g0[0]), 32'd0);
    check("t5_flush1", 32'(g1[0]), 32'd0);
    cyc(nop, nop);
    // drive stall counters into saturation
    for (int i = 0; i < 8; i++) begin
      cyc(op(10, 0, 0, 1, 0, 0, 1), nop);
      for (int j = 0; j < 3; j++) cyc(op(11, 10, 0), nop);
    end
    cyc(op(11, 10, 0), nop);
    check("t6_sat_a", 32'(pt[0]), 32'd15);
    check("t6_sat_b", 32'(pt[1]), 32'd15);
    // asynchronous reset in the middle of a MAC
    cyc(op(22, 0, 0, 1, 0, 0, 1), nop);
    cyc(op(23, 1, 2), nop);
    #1;
    reset = 1'b0;
    #1;
    mclear(0);
    mclear(1);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t6_rst_busy_%0d", k), bv[k], 32'd0);
      check($sformatf("t6_rst_issue_%0d", k), 32'(g0[k]), 32'd0);
      check($sformatf("t6_rst_perf_%0d", k), 32'(pt[k]), 32'd0);
    end
    @(negedge clk);
    release_reset();
    cyc(op(24, 22, 23), nop);
    check("t6_after_rst", 32'(g0[1]), 32'd1);
    // random bundles over a small register window
    for (int i = 0; i < 400; i++) cyc(rnd(), rnd(), ($urandom % 6) == 0, ($urandom % 10) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
